// File: rtl/pu_msp430_wakeup_ctrl.sv
// Wakeup controller for a bank of asynchronous wakeup capture cells.
// Synchronizes the cell flags and masks them. Picks the lowest pending
// index and hands it to the requester with a req/ack handshake. After the
// ack it pulses that cell's clear and waits for the flag to drop. A cell
// that never releases raises a sticky error.
module pu_msp430_wakeup_ctrl #(
  parameter int NSRC        = 8,
  parameter int SYNC_STAGES = 2,
  parameter int CLR_CYCLES  = 2,
  parameter int TMO_CYCLES  = 16,
  localparam int IDW        = (NSRC > 1) ? $clog2(NSRC) : 1
) (
  input  logic            mclk,
  input  logic            puc_rst,
  input  logic [NSRC-1:0] wkup_in,
  input  logic [NSRC-1:0] wkup_en,
  input  logic            wkup_ack,
  input  logic            err_clr,
  output logic [NSRC-1:0] wkup_clear,
  output logic            wkup_req,
  output logic [IDW-1:0]  wkup_id,
  output logic [NSRC-1:0] wkup_pend,
  output logic            wkup_err
);

  // Clear counter holds CLR_CYCLES-1 down to 0; timeout counter holds TMO_CYCLES.
  localparam int CCW = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
  localparam int TCW = $clog2(TMO_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    CLEAR    = 2'd2,
    WAIT_LOW = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic            req_q, req_d;
  logic [IDW-1:0]  id_q, id_d;
  logic [NSRC-1:0] clear_q, clear_d;
  logic [CCW-1:0]  clr_cnt_q, clr_cnt_d;
  logic [TCW-1:0]  tmo_cnt_q, tmo_cnt_d;
  logic            err_q, err_d;
  logic            err_set;

  logic [NSRC-1:0] sync_q [SYNC_STAGES];
  logic [NSRC-1:0] sync_d [SYNC_STAGES];
  logic [NSRC-1:0] wkup_sync;

  logic [IDW-1:0]  sel;
  logic [NSRC-1:0] id_onehot;
  logic            pend_sel;
  logic            sync_sel;

  // Synchronizer chain: stage 0 samples the raw cell flags, each later stage
  // samples the one before it.
  always_comb begin
    sync_d[0] = wkup_in;
    for (int s = 1; s < SYNC_STAGES; s++) begin
      sync_d[s] = sync_q[s-1];
    end
  end

  // Synchronizer registers.
  always_ff @(posedge mclk) begin
    for (int s = 0; s < SYNC_STAGES; s++) begin
      if (puc_rst) begin
        sync_q[s] <= '0;
      end else begin
        sync_q[s] <= sync_d[s];
      end
    end
  end

  assign wkup_sync = sync_q[SYNC_STAGES-1];
  assign wkup_pend = wkup_sync & wkup_en;

  // Fixed-priority pick. Scanning from the top down lets the lowest index win.
  always_comb begin
    sel = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (wkup_pend[i]) begin
        sel = IDW'(i);
      end
    end
  end

  // Selecting through a one-hot mask keeps index decode in range for any NSRC.
  assign id_onehot = NSRC'(1) << id_q;
  assign pend_sel  = |(wkup_pend & id_onehot);
  assign sync_sel  = |(wkup_sync & id_onehot);

  // Next-state and next-output logic for the handshake and clear sequencer.
  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    id_d      = id_q;
    clear_d   = clear_q;
    clr_cnt_d = clr_cnt_q;
    tmo_cnt_d = tmo_cnt_q;
    err_set   = 1'b0;

    case (state_q)
      IDLE: begin
        req_d   = 1'b0;
        clear_d = '0;
        if (|wkup_pend) begin
          id_d    = sel;
          req_d   = 1'b1;
          state_d = REQ;
        end
      end

      REQ: begin
        // An ack beats a withdrawal in the same cycle.
        if (wkup_ack) begin
          req_d     = 1'b0;
          clear_d   = id_onehot;
          clr_cnt_d = CCW'(CLR_CYCLES - 1);
          state_d   = CLEAR;
        end else if (!pend_sel) begin
          req_d   = 1'b0;
          state_d = IDLE;
        end
      end

      CLEAR: begin
        if (clr_cnt_q == '0) begin
          clear_d   = '0;
          tmo_cnt_d = TCW'(TMO_CYCLES);
          state_d   = WAIT_LOW;
        end else begin
          clr_cnt_d = clr_cnt_q - 1'b1;
        end
      end

      WAIT_LOW: begin
        // A cell still high after TMO_CYCLES checks is reported stuck.
        if (!sync_sel) begin
          state_d = IDLE;
        end else if (tmo_cnt_q <= TCW'(1)) begin
          tmo_cnt_d = '0;
          err_set   = 1'b1;
          state_d   = IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q - 1'b1;
        end
      end

      default: begin
        req_d   = 1'b0;
        clear_d = '0;
        state_d = IDLE;
      end
    endcase

    // A new timeout takes priority over a simultaneous clear request.
    err_d = err_set | (err_q & ~err_clr);
  end

  // State, handshake, clear and error registers.
  always_ff @(posedge mclk) begin
    if (puc_rst) begin
      state_q   <= IDLE;
      req_q     <= 1'b0;
      id_q      <= '0;
      clear_q   <= '0;
      clr_cnt_q <= '0;
      tmo_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      id_q      <= id_d;
      clear_q   <= clear_d;
      clr_cnt_q <= clr_cnt_d;
      tmo_cnt_q <= tmo_cnt_d;
      err_q     <= err_d;
    end
  end

  assign wkup_clear = clear_q;
  assign wkup_req   = req_q;
  assign wkup_id    = id_q;
  assign wkup_err   = err_q;

endmodule

// File: tb/tb_pu_msp430_wakeup_ctrl.sv
// Directed bench for pu_msp430_wakeup_ctrl. Expected observations are queued
// with the cycle they fall due and checked when that cycle is reached. A
// small cell model drops each flag when its clear is seen, unless the cell
// is marked stuck.
module tb_pu_msp430_wakeup_ctrl;

  localparam int NSRC = 8;

  localparam int K_REQ  = 0;
  localparam int K_ID   = 1;
  localparam int K_CLR  = 2;
  localparam int K_ERR  = 3;
  localparam int K_PEND = 4;

  logic            mclk = 1'b0;
  logic            puc_rst;
  logic [NSRC-1:0] wkup_in;
  logic [NSRC-1:0] wkup_en;
  logic            wkup_ack;
  logic            err_clr;
  logic [NSRC-1:0] wkup_clear;
  logic            wkup_req;
  logic [2:0]      wkup_id;
  logic [NSRC-1:0] wkup_pend;
  logic            wkup_err;

  logic [NSRC-1:0] stuck;

  typedef struct {
    int          due;
    int          kind;
    logic [15:0] val;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   errors = 0;
  int   checks = 0;

  pu_msp430_wakeup_ctrl #(
    .NSRC(NSRC), .SYNC_STAGES(2), .CLR_CYCLES(2), .TMO_CYCLES(16)
  ) dut (
    .mclk(mclk), .puc_rst(puc_rst), .wkup_in(wkup_in), .wkup_en(wkup_en),
    .wkup_ack(wkup_ack), .err_clr(err_clr), .wkup_clear(wkup_clear),
    .wkup_req(wkup_req), .wkup_id(wkup_id), .wkup_pend(wkup_pend),
    .wkup_err(wkup_err)
  );

  always #5 mclk = ~mclk;

  task automatic expect_at(input int dly, input int kind, input logic [15:0] val,
                           input string tag);
    exp_t e;
    e.due  = cyc + dly;
    e.kind = kind;
    e.val  = val;
    e.tag  = tag;
    sb.push_back(e);
  endtask

  function automatic logic [15:0] observe(input int kind);
    case (kind)
      K_REQ:   observe = 16'(wkup_req);
      K_ID:    observe = 16'(wkup_id);
      K_CLR:   observe = 16'(wkup_clear);
      K_ERR:   observe = 16'(wkup_err);
      K_PEND:  observe = 16'(wkup_pend);
      default: observe = 16'hDEAD;
    endcase
  endfunction

  // One clock: sample 1 ns after the edge, retire due entries, then update the cells.
  task automatic tick();
    int          k;
    logic [15:0] obs;
    @(posedge mclk);
    #1;
    cyc++;
    k = 0;
    while (k < sb.size()) begin
      if (sb[k].due == cyc) begin
        obs = observe(sb[k].kind);
        checks++;
        assert (obs === sb[k].val) else begin
          errors++;
          $error("FAIL %s cyc=%0d observed=%0h expected=%0h", sb[k].tag, cyc, obs, sb[k].val);
        end
        $display("check %s cyc=%0d observed=%0h expected=%0h", sb[k].tag, cyc, obs, sb[k].val);
        sb.delete(k);
      end else begin
        k++;
      end
    end
    for (int i = 0; i < NSRC; i++) begin
      if (wkup_clear[i] && !stuck[i]) wkup_in[i] = 1'b0;
    end
  endtask

  task automatic ticks(input int n);
    for (int j = 0; j < n; j++) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d observed=running expected=finished", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    puc_rst  = 1'b1;
    wkup_in  = '0;
    wkup_en  = 8'hFF;
    wkup_ack = 1'b0;
    err_clr  = 1'b0;
    stuck    = '0;

    // Reset state.
    expect_at(1, K_REQ, 0, "rst_req");
    expect_at(1, K_CLR, 0, "rst_clr");
    expect_at(1, K_ERR, 0, "rst_err");
    expect_at(1, K_ID,  0, "rst_id");
    ticks(2);
    puc_rst = 1'b0;

    // Single source 3.
    wkup_in[3] = 1'b1;
    expect_at(1, K_PEND, 8'h00, "s3_pend_early");
    expect_at(2, K_PEND, 8'h08, "s3_pend");
    expect_at(2, K_REQ,  0,     "s3_req_early");
    expect_at(3, K_REQ,  1,     "s3_req");
    expect_at(3, K_ID,   3,     "s3_id");
    ticks(3);
    wkup_ack = 1'b1;
    expect_at(1, K_CLR,  8'h08, "s3_clr1");
    expect_at(1, K_REQ,  0,     "s3_req_drop");
    expect_at(2, K_CLR,  8'h08, "s3_clr2");
    expect_at(3, K_CLR,  8'h00, "s3_clr_end");
    expect_at(3, K_PEND, 8'h00, "s3_pend_low");
    expect_at(5, K_REQ,  0,     "s3_idle_req");
    expect_at(5, K_ERR,  0,     "s3_no_err");
    tick();
    wkup_ack = 1'b0;
    ticks(4);

    // Priority: 2 and 5 together, 2 first.
    wkup_in = 8'h24;
    expect_at(2, K_PEND, 8'h24, "pri_pend");
    expect_at(3, K_REQ,  1,     "pri_req2");
    expect_at(3, K_ID,   2,     "pri_id2");
    ticks(3);
    wkup_ack = 1'b1;
    expect_at(1, K_CLR,  8'h04, "pri_clr2a");
    expect_at(2, K_CLR,  8'h04, "pri_clr2b");
    expect_at(3, K_CLR,  8'h00, "pri_clr2_end");
    expect_at(3, K_PEND, 8'h20, "pri_pend5");
    expect_at(4, K_REQ,  0,     "pri_wait_req");
    expect_at(5, K_REQ,  1,     "pri_req5");
    expect_at(5, K_ID,   5,     "pri_id5");
    tick();
    wkup_ack = 1'b0;
    ticks(4);
    wkup_ack = 1'b1;
    expect_at(1, K_CLR, 8'h20, "pri_clr5a");
    expect_at(2, K_CLR, 8'h20, "pri_clr5b");
    expect_at(3, K_CLR, 8'h00, "pri_clr5_end");
    expect_at(5, K_REQ, 0,     "pri_idle");
    expect_at(5, K_ERR, 0,     "pri_no_err");
    tick();
    wkup_ack = 1'b0;
    ticks(4);

    // Withdraw: enable dropped before ack.
    wkup_in[1] = 1'b1;
    expect_at(3, K_REQ, 1, "wd_req");
    expect_at(3, K_ID,  1, "wd_id");
    ticks(3);
    wkup_en[1] = 1'b0;
    expect_at(1, K_REQ,  0,     "wd_req_drop");
    expect_at(1, K_CLR,  8'h00, "wd_no_clr1");
    expect_at(2, K_CLR,  8'h00, "wd_no_clr2");
    expect_at(2, K_PEND, 8'h00, "wd_pend_masked");
    ticks(2);
    wkup_en[1] = 1'b1;
    expect_at(1, K_REQ, 1, "wd_rereq");
    expect_at(1, K_ID,  1, "wd_reid");
    tick();
    // Ack and withdraw in the same cycle: ack wins.
    wkup_ack   = 1'b1;
    wkup_en[1] = 1'b0;
    expect_at(1, K_CLR, 8'h02, "wdack_clr1");
    expect_at(1, K_REQ, 0,     "wdack_req");
    expect_at(2, K_CLR, 8'h02, "wdack_clr2");
    expect_at(3, K_CLR, 8'h00, "wdack_clr_end");
    expect_at(5, K_REQ, 0,     "wdack_idle");
    expect_at(5, K_ERR, 0,     "wdack_no_err");
    tick();
    wkup_ack = 1'b0;
    wkup_en  = 8'hFF;
    ticks(4);

    // Masking, with ack held outside REQ.
    wkup_en    = 8'h7F;
    wkup_in[7] = 1'b1;
    wkup_ack   = 1'b1;
    expect_at(4, K_PEND, 8'h00, "mask_pend");
    expect_at(4, K_REQ,  0,     "mask_req");
    expect_at(4, K_CLR,  8'h00, "mask_ack_ignored");
    ticks(4);
    wkup_ack = 1'b0;
    wkup_en  = 8'hFF;
    expect_at(1, K_REQ,  1,     "mask_req7");
    expect_at(1, K_ID,   7,     "mask_id7");
    expect_at(1, K_PEND, 8'h80, "mask_pend7");
    tick();
    wkup_ack = 1'b1;
    expect_at(1, K_CLR, 8'h80, "mask_clr7a");
    expect_at(2, K_CLR, 8'h80, "mask_clr7b");
    expect_at(3, K_CLR, 8'h00, "mask_clr7_end");
    expect_at(5, K_REQ, 0,     "mask_idle");
    tick();
    wkup_ack = 1'b0;
    ticks(4);

    // Timeout: source 0 stays high through the clear.
    stuck[0]   = 1'b1;
    wkup_in[0] = 1'b1;
    expect_at(3, K_REQ, 1, "tmo_req");
    expect_at(3, K_ID,  0, "tmo_id");
    ticks(3);
    wkup_ack = 1'b1;
    expect_at(1,  K_CLR, 8'h01, "tmo_clr1");
    expect_at(2,  K_CLR, 8'h01, "tmo_clr2");
    expect_at(3,  K_CLR, 8'h00, "tmo_clr_end");
    expect_at(18, K_ERR, 0,     "tmo_err_early");
    expect_at(19, K_ERR, 1,     "tmo_err");
    tick();
    wkup_ack = 1'b0;
    ticks(18);
    // err_clr alone clears; stuck source is re-arbitrated.
    err_clr = 1'b1;
    expect_at(1, K_ERR, 0, "errclr_alone");
    expect_at(1, K_REQ, 1, "tmo_rearb");
    tick();
    err_clr  = 1'b0;
    wkup_ack = 1'b1;
    expect_at(18, K_ERR, 0, "tmo2_err_early");
    expect_at(19, K_ERR, 1, "tmo2_set_wins");
    tick();
    wkup_ack = 1'b0;
    ticks(17);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    expect_at(1, K_REQ, 1, "tmo3_req");
    tick();
    wkup_ack = 1'b1;
    expect_at(1, K_CLR, 8'h01, "tmo3_clr");
    expect_at(1, K_ERR, 1,     "tmo3_err_held");
    tick();
    wkup_ack = 1'b0;

    // Reset in the middle of CLEAR.
    stuck   = '0;
    wkup_in = 8'h00;
    puc_rst = 1'b1;
    expect_at(1, K_CLR, 8'h00, "midrst_clr");
    expect_at(1, K_REQ, 0,     "midrst_req");
    expect_at(1, K_ERR, 0,     "midrst_err");
    expect_at(1, K_ID,  0,     "midrst_id");
    tick();
    puc_rst = 1'b0;
    expect_at(4, K_REQ,  0,     "post_rst_req");
    expect_at(4, K_CLR,  8'h00, "post_rst_clr");
    expect_at(4, K_PEND, 8'h00, "post_rst_pend");
    ticks(4);

    if (sb.size() != 0) begin
      errors += sb.size();
      checks += sb.size();
      $display("FAIL scoreboard observed=%0d expected=0 entries left", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pu_msp430_wakeup_ctrl.md
Name: pu_msp430_wakeup_ctrl

Overview:
- Central controller for a bank of NSRC asynchronous wakeup capture cells. Each cell sets a flag on an async event and is cleared by a glitch-free clear.
- Synchronizes the cell outputs into the mclk domain, masks them, and picks one pending source by fixed priority (lowest index wins).
- Presents the winner to the CPU/clock module through a req/ack handshake, then sequences that cell's clear pulse.
- Checks that the cell actually released, and flags a sticky error if it did not.

Parameters:
- NSRC, 8, number of wakeup sources/cells (1..16).
- SYNC_STAGES, 2, synchronizer depth per source (>=2).
- CLR_CYCLES, 2, width of the wkup_clear pulse in mclk cycles (>=1).
- TMO_CYCLES, 16, maximum WAIT_LOW cycles before timeout (>=SYNC_STAGES+1).

Ports:
- mclk, in, 1, main clock.
- puc_rst, in, 1, synchronous active-high reset.
- wkup_in, in, NSRC, asynchronous wakeup flags from the cells.
- wkup_en, in, NSRC, per-source enable mask (mclk domain).
- wkup_ack, in, 1, requester accepts the presented wakeup.
- err_clr, in, 1, clears wkup_err.
- wkup_clear, out, NSRC, one-hot clear to the cells; registered, glitch-free.
- wkup_req, out, 1, wakeup request; registered.
- wkup_id, out, max(1,$clog2(NSRC)), index of the presented source; registered.
- wkup_pend, out, NSRC, wkup_sync & wkup_en.
- wkup_err, out, 1, sticky clear-timeout flag; registered.

Behaviour:
- Reset:
  - All synchronizer flops, state, counters, wkup_clear, wkup_req, wkup_id and wkup_err go to 0 at the mclk edge where puc_rst=1.
  - Reset mid-operation drops any active clear and request at that edge and returns to IDLE.
- Synchronization: each wkup_in bit passes through SYNC_STAGES flops to give wkup_sync. Sync latency is SYNC_STAGES cycles.
- Arbitration: sel = lowest index i with wkup_pend[i]=1. It is evaluated only in IDLE.
- FSM states: IDLE, REQ, CLEAR, WAIT_LOW.
- IDLE:
  - If |wkup_pend, latch wkup_id=sel, set wkup_req=1 and go to REQ (request visible 1 cycle after pend).
  - Otherwise stay; wkup_req=0.
- REQ:
  - wkup_req=1 and wkup_id stable.
  - If wkup_ack=1: go to CLEAR, wkup_req=0 next cycle, assert wkup_clear[wkup_id]=1 next cycle, load the clear counter.
  - Else if wkup_pend[wkup_id]=0 (enable dropped or source fell): withdraw. wkup_req=0 and go to IDLE.
  - If ack and withdraw occur in the same cycle, ack wins.
- CLEAR:
  - wkup_clear[wkup_id]=1 for exactly CLR_CYCLES cycles; all other clear bits stay 0.
  - After the last cycle go to WAIT_LOW with wkup_clear=0, and load the timeout counter with TMO_CYCLES.
- WAIT_LOW:
  - If wkup_sync[wkup_id]=0, go to IDLE.
  - Else decrement the counter. At 0, set wkup_err=1 and go to IDLE.
  - A source still stuck high may be re-arbitrated from IDLE.
- Ignored inputs: wkup_ack outside REQ is ignored. Changes to wkup_en outside REQ affect only the next arbitration.
- Error flag: wkup_err set and err_clr in the same cycle leaves wkup_err=1 (set wins). Otherwise err_clr=1 clears it next cycle.
- Lost events: an event on the selected source arriving during CLEAR is lost, because the cell is held in reset. Events on other sources remain pending.
- Counter widths: sized for CLR_CYCLES and TMO_CYCLES. No wrap is possible; counters saturate at 0.
- wkup_clear is driven only from flops, never from combinational decode, so it is glitch-free.

Test Plan:
- Reset: drive wkup_in=8'h00 then pulse puc_rst mid-CLEAR → wkup_clear=0, wkup_req=0, wkup_err=0 on the next edge; FSM in IDLE.
- Single source: wkup_in[3]=1, en=8'hFF → wkup_req=1 at cycle SYNC_STAGES+1 with wkup_id=3. Ack → wkup_clear=8'h08 for 2 cycles; model the cell dropping wkup_in[3] → back in IDLE, no error.
- Priority: wkup_in=8'h24 simultaneously → id=2 served first, then id=5 presented after 2's WAIT_LOW completes.
- Withdraw: wkup_in[1]=1, request raised, then en[1]=0 before ack → wkup_req drops next cycle, no clear issued. Ack in the same cycle as withdraw → clear still issued.
- Timeout: hold wkup_in[0]=1 despite clear → wkup_err=1 after 16 WAIT_LOW cycles. err_clr with a new timeout in the same cycle → stays 1. err_clr alone → 0.
- Masking: wkup_in=8'h80, en=8'h7F → no request; wkup_pend=0. Set en[7]=1 → request with id=7.
